// File: rtl/shot_clock_pkg.sv
// Shared definitions for the shot clock controller: FSM state encoding,
// default BCD presets and the BCD zero value used for expiry detection.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2,
        EXPIRE = 2'd3
    } state_t;

    localparam logic [7:0] PRESET_FULL_DEF  = 8'h24;
    localparam logic [7:0] PRESET_SHORT_DEF = 8'h14;
    localparam logic [7:0] BCD_ZERO         = 8'h00;

endpackage

// File: rtl/shot_clock_ctrl_tick_prescaler.sv
// Divides the clock down to the count tick. The counter advances while en
// is high, returns to zero on clr (clr wins over en) and wraps after
// TICK_DIV cycles; tick is high in the cycle the wrap happens.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Divider counter: clear, advance with wrap, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot clock control stage: drives the count enable and synchronous preset
// load of the cascaded BCD down-counters and sounds the expiry buzzer.
// Optional build macro SHOT_AUTO_RELOAD_EN: when defined, leaving EXPIRE
// loads PRESET_FULL automatically and parks in HALT instead of IDLE.
module shot_clock_ctrl
    import shot_clock_pkg::*;
#(
    parameter int         TICK_DIV     = 50000000,
    parameter logic [7:0] PRESET_FULL  = PRESET_FULL_DEF,
    parameter logic [7:0] PRESET_SHORT = PRESET_SHORT_DEF,
    parameter int         BUZZ_TICKS   = 3
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       start,
    input  logic       pause,
    input  logic       reset24,
    input  logic       reset14,
    input  logic [3:0] q_tens,
    input  logic [3:0] q_units,
    output logic       cnt_en,
    output logic       pe_n,
    output logic [3:0] d_tens,
    output logic [3:0] d_units,
    output logic       buzzer,
    output logic [1:0] state
);

    localparam int            BW        = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS) : 1;
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_TICKS - 1);

    state_t        state_q, state_n;
    logic          cnt_en_n, pe_n_n, buzzer_n;
    logic [7:0]    d_q, d_n;
    logic [BW-1:0] buzz_cnt, buzz_cnt_n;
    logic          load_req, q_zero, pre_en, pre_clr, tick;

    assign load_req = reset24 || reset14;
    assign q_zero   = ({q_tens, q_units} == BCD_ZERO);

    // The prescaler runs only while counting or buzzing; a pause freezes it
    // so a resume finishes the partial second. Loads and expiry entry restart it.
    assign pre_en  = !load_req &&
                     (((state_q == RUN) && !pause && !q_zero) || (state_q == EXPIRE));
    assign pre_clr = load_req || ((state_q == RUN) && !pause && q_zero);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (CP),
        .rst  (CR),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    // State and all outputs are registered.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q  <= IDLE;
            cnt_en   <= 1'b0;
            pe_n     <= 1'b1;
            d_q      <= PRESET_FULL;
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
        end else begin
            state_q  <= state_n;
            cnt_en   <= cnt_en_n;
            pe_n     <= pe_n_n;
            d_q      <= d_n;
            buzzer   <= buzzer_n;
            buzz_cnt <= buzz_cnt_n;
        end
    end

    // Next state and outputs; requests resolve as reset24 > reset14 > pause > start.
    always_comb begin
        state_n    = state_q;
        cnt_en_n   = 1'b0;
        pe_n_n     = 1'b1;
        d_n        = d_q;
        buzzer_n   = buzzer;
        buzz_cnt_n = buzz_cnt;
        if (load_req) begin
            state_n    = HALT;
            pe_n_n     = 1'b0;
            d_n        = reset24 ? PRESET_FULL : PRESET_SHORT;
            buzzer_n   = 1'b0;
            buzz_cnt_n = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Waits for an explicit load; start and pause do nothing.
                end
                HALT: begin
                    if (!pause && start) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = HALT;
                    end else if (q_zero) begin
                        state_n    = EXPIRE;
                        buzzer_n   = 1'b1;
                        buzz_cnt_n = '0;
                    end else begin
                        cnt_en_n = tick;
                    end
                end
                EXPIRE: begin
                    buzzer_n = 1'b1;
                    if (tick) begin
                        if (buzz_cnt == BUZZ_LAST) begin
                            buzzer_n   = 1'b0;
                            buzz_cnt_n = '0;
`ifdef SHOT_AUTO_RELOAD_EN
                            state_n    = HALT;
                            pe_n_n     = 1'b0;
                            d_n        = PRESET_FULL;
`else
                            state_n    = IDLE;
`endif
                        end else begin
                            buzz_cnt_n = buzz_cnt + BW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign d_tens  = d_q[7:4];
    assign d_units = d_q[3:0];
    assign state   = state_q;

endmodule
